// File: rtl/pipeid_hazard.sv
// IF/ID pipeline register with load-use stall control and
// EX/MEM/WB operand forwarding selects for the decode stage.
module pipeid_hazard #(
   parameter int WIDTH    = 32,
   parameter int RA_W     = 5,
   parameter int LOAD_LAT = 1,
   parameter int BR_FLUSH = 0
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] fpc4,
   input  logic [WIDTH-1:0] finst,
   output logic [WIDTH-1:0] dpc4,
   output logic [WIDTH-1:0] dinst,
   input  logic             use_rs,
   input  logic             use_rt,
   input  logic             taken,
   input  logic [RA_W-1:0]  ern,
   input  logic             ewreg,
   input  logic             em2reg,
   input  logic [RA_W-1:0]  mrn,
   input  logic             mwreg,
   input  logic             mm2reg,
   input  logic [RA_W-1:0]  wrn,
   input  logic             wwreg,
   output logic [2:0]       fwda,
   output logic [2:0]       fwdb,
   output logic             wpcir,
   output logic             dbubble
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [1:0] LD_CNT = 2'(LOAD_LAT - 1);
   localparam logic [2:0] F_REG = 3'd0;
   localparam logic [2:0] F_EALU = 3'd1;
   localparam logic [2:0] F_MALU = 3'd2;
   localparam logic [2:0] F_MMO = 3'd3;
   localparam logic [2:0] F_WDI = 3'd4;

   logic [RA_W-1:0] rs;
   logic [RA_W-1:0] rt;
   logic [1:0]      scnt;
   logic [1:0]      scnt_nxt;
   state_t          state;
   logic            lu;
   logic            stall;
   logic            flush;

   assign rs = dinst[21 +: RA_W];
   assign rt = dinst[16 +: RA_W];

   // EX results from a load are not ready yet, so EX is skipped for loads
   function automatic logic [2:0] fwd_sel(
      input logic [RA_W-1:0] s,
      input logic [RA_W-1:0] e_rn,
      input logic            e_wr,
      input logic            e_ld,
      input logic [RA_W-1:0] m_rn,
      input logic            m_wr,
      input logic            m_ld,
      input logic [RA_W-1:0] w_rn,
      input logic            w_wr
   );
      logic [2:0] sel;
      sel = F_REG;
      if (s == '0)
         sel = F_REG;
      else if (e_wr && e_rn == s && !e_ld)
         sel = F_EALU;
      else if (m_wr && m_rn == s)
         sel = m_ld ? F_MMO : F_MALU;
      else if (w_wr && w_rn == s)
         sel = F_WDI;
      return sel;
   endfunction

   always_comb begin
      fwda = fwd_sel(rs, ern, ewreg, em2reg,
                     mrn, mwreg, mm2reg, wrn, wwreg);
      fwdb = fwd_sel(rt, ern, ewreg, em2reg,
                     mrn, mwreg, mm2reg, wrn, wwreg);
   end

   assign lu = ewreg & em2reg & (ern != '0)
             & ((use_rs & (ern == rs))
              | (use_rt & (ern == rt)));

   assign state = (scnt != 2'd0) ? HOLD : RUN;

   always_comb begin
      scnt_nxt = scnt;
      stall    = 1'b0;
      unique case (state)
         RUN: begin
            stall = lu;
            if (lu)
               scnt_nxt = LD_CNT;
         end
         HOLD: begin
            stall    = 1'b1;
            scnt_nxt = scnt - 2'd1;
         end
         default: begin
            scnt_nxt = 2'd0;
            stall    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         scnt <= 2'd0;
      else
         scnt <= scnt_nxt;
   end

   assign wpcir   = ~stall;
   assign dbubble = stall;

   // a taken branch is only honoured once the stall has cleared
   assign flush = (BR_FLUSH != 0) & taken;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dpc4  <= '0;
         dinst <= '0;
      end else if (!stall) begin
         dpc4  <= fpc4;
         dinst <= flush ? '0 : finst;
      end
   end

endmodule

// File: tb/tb_pipeid_hazard.sv
// Directed bench: two configurations (LAT1/flush, LAT2/delay slot)
// driven with shared stimulus.
module tb_pipeid_hazard;

   logic        clock;
   logic        resetn;
   logic [31:0] fpc4, finst;
   logic        use_rs, use_rt, taken;
   logic [4:0]  ern, mrn, wrn;
   logic        ewreg, em2reg, mwreg, mm2reg, wwreg;

   logic [31:0] dpc4_1, dinst_1, dpc4_2, dinst_2;
   logic [2:0]  fwda_1, fwdb_1, fwda_2, fwdb_2;
   logic        wpcir_1, dbub_1, wpcir_2, dbub_2;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] I_FWD = 32'h0064_3020; // add $6,$3,$4
   localparam logic [31:0] I_ADD = 32'h00A7_3020; // add $6,$5,$7
   localparam logic [31:0] I_LW  = 32'h8C22_0004;
   localparam logic [31:0] I_Z   = 32'h0000_3020; // add $6,$0,$0

   pipeid_hazard #(.WIDTH(32), .RA_W(5), .LOAD_LAT(1), .BR_FLUSH(1)) u1 (
      .clock(clock), .resetn(resetn), .fpc4(fpc4), .finst(finst),
      .dpc4(dpc4_1), .dinst(dinst_1), .use_rs(use_rs), .use_rt(use_rt),
      .taken(taken), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .wrn(wrn),
      .wwreg(wwreg), .fwda(fwda_1), .fwdb(fwdb_1), .wpcir(wpcir_1),
      .dbubble(dbub_1)
   );

   pipeid_hazard #(.WIDTH(32), .RA_W(5), .LOAD_LAT(2), .BR_FLUSH(0)) u2 (
      .clock(clock), .resetn(resetn), .fpc4(fpc4), .finst(finst),
      .dpc4(dpc4_2), .dinst(dinst_2), .use_rs(use_rs), .use_rt(use_rt),
      .taken(taken), .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .wrn(wrn),
      .wwreg(wwreg), .fwda(fwda_2), .fwdb(fwdb_2), .wpcir(wpcir_2),
      .dbubble(dbub_2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] ern;
      logic       ewreg;
      logic       em2reg;
      logic [4:0] mrn;
      logic       mwreg;
      logic       mm2reg;
      logic [4:0] wrn;
      logic       wwreg;
      logic [2:0] efa;
      logic [2:0] efb;
   } vec_t;

   vec_t tv[9];

   function automatic vec_t mk(int e, int ew, int el, int m, int mw,
                               int ml, int w, int ww, int fa, int fb);
      vec_t v;
      v.ern = 5'(e);   v.ewreg = 1'(ew); v.em2reg = 1'(el);
      v.mrn = 5'(m);   v.mwreg = 1'(mw); v.mm2reg = 1'(ml);
      v.wrn = 5'(w);   v.wwreg = 1'(ww);
      v.efa = 3'(fa);  v.efb = 3'(fb);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic pipe_clear;
      ewreg = 0; em2reg = 0; ern = 0;
      mwreg = 0; mm2reg = 0; mrn = 0;
      wwreg = 0; wrn = 0;
      use_rs = 0; use_rt = 0; taken = 0;
   endtask

   task automatic ex_load5;
      ewreg = 1; em2reg = 1; ern = 5'd5;
      mwreg = 0; mm2reg = 0; mrn = 0;
      wwreg = 0; wrn = 0;
   endtask

   task automatic mem_load5;
      ewreg = 0; em2reg = 0; ern = 0;
      mwreg = 1; mm2reg = 1; mrn = 5'd5;
      wwreg = 0; wrn = 0;
   endtask

   task automatic wb_load5;
      ewreg = 0; em2reg = 0; ern = 0;
      mwreg = 0; mm2reg = 0; mrn = 0;
      wwreg = 1; wrn = 5'd5;
   endtask

   initial begin
      tv[0] = mk(3, 1, 0, 3, 1, 0, 0, 0, 1, 0);
      tv[1] = mk(3, 0, 0, 3, 1, 0, 0, 0, 2, 0);
      tv[2] = mk(3, 0, 0, 3, 1, 1, 0, 0, 3, 0);
      tv[3] = mk(3, 0, 0, 3, 0, 1, 3, 1, 4, 0);
      tv[4] = mk(4, 1, 0, 3, 1, 1, 4, 1, 3, 1);
      tv[5] = mk(4, 1, 1, 4, 1, 0, 3, 1, 4, 2);
      tv[6] = mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tv[7] = mk(4, 0, 0, 4, 0, 0, 4, 0, 0, 0);
      tv[8] = mk(7, 1, 0, 3, 1, 0, 4, 1, 2, 4);

      resetn = 0;
      fpc4 = 0; finst = 0;
      pipe_clear();
      #12;
      chk("rst_dpc4", dpc4_1, 0);
      chk("rst_dinst", dinst_1, 0);
      chk("rst_wpcir", 32'(wpcir_1), 1);
      chk("rst_dbub", 32'(dbub_1), 0);
      chk("rst_fwda", 32'(fwda_1), 0);
      chk("rst_fwdb", 32'(fwdb_2), 0);
      tick();
      resetn = 1;

      // mid-cycle asynchronous reset
      finst = I_ADD; fpc4 = 32'h44;
      tick();
      chk("ld_dinst", dinst_1, I_ADD);
      chk("ld_dpc4", dpc4_2, 32'h44);
      #2 resetn = 0;
      #1;
      chk("arst_dinst", dinst_1, 0);
      chk("arst_dpc4", dpc4_2, 0);
      chk("arst_wpcir", 32'(wpcir_1), 1);
      chk("arst_dbub", 32'(dbub_2), 0);
      tick();
      resetn = 1;

      // forwarding table
      finst = I_FWD; fpc4 = 32'h100;
      tick();
      chk("fwd_dinst", dinst_1, I_FWD);
      for (int i = 0; i < 9; i++) begin
         ern = tv[i].ern; ewreg = tv[i].ewreg; em2reg = tv[i].em2reg;
         mrn = tv[i].mrn; mwreg = tv[i].mwreg; mm2reg = tv[i].mm2reg;
         wrn = tv[i].wrn; wwreg = tv[i].wwreg;
         #2;
         chk($sformatf("fwda_v%0d", i), 32'(fwda_1), 32'(tv[i].efa));
         chk($sformatf("fwdb_v%0d", i), 32'(fwdb_1), 32'(tv[i].efb));
         chk($sformatf("fwda2_v%0d", i), 32'(fwda_2), 32'(tv[i].efa));
         chk($sformatf("wpcir_v%0d", i), 32'(wpcir_1), 1);
         tick();
      end

      // load-use: LAT1 one bubble, LAT2 two bubbles
      pipe_clear();
      finst = I_ADD; fpc4 = 32'h104;
      tick();
      finst = 32'h1111_1111; fpc4 = 32'h108;
      ex_load5(); use_rs = 1; use_rt = 1;
      #2;
      chk("lu1_c1_wpcir", 32'(wpcir_1), 0);
      chk("lu1_c1_dbub", 32'(dbub_1), 1);
      chk("lu2_c1_wpcir", 32'(wpcir_2), 0);
      tick();
      mem_load5();
      #2;
      chk("lu1_c2_dinst", dinst_1, I_ADD);
      chk("lu1_c2_dpc4", dpc4_1, 32'h104);
      chk("lu1_c2_fwda", 32'(fwda_1), 3);
      chk("lu1_c2_wpcir", 32'(wpcir_1), 1);
      chk("lu1_c2_dbub", 32'(dbub_1), 0);
      chk("lu2_c2_wpcir", 32'(wpcir_2), 0);
      chk("lu2_c2_dbub", 32'(dbub_2), 1);
      chk("lu2_c2_dinst", dinst_2, I_ADD);
      tick();
      wb_load5();
      #2;
      chk("lu1_c3_dinst", dinst_1, 32'h1111_1111);
      chk("lu2_c3_dinst", dinst_2, I_ADD);
      chk("lu2_c3_wpcir", 32'(wpcir_2), 1);
      chk("lu2_c3_fwda", 32'(fwda_2), 4);
      tick();
      chk("lu2_c4_dinst", dinst_2, 32'h1111_1111);

      // reset during HOLD
      pipe_clear();
      finst = I_ADD; fpc4 = 32'h104;
      tick();
      ex_load5(); use_rs = 1;
      tick();
      mem_load5();
      #2;
      chk("hrst_pre_wpcir", 32'(wpcir_2), 0);
      resetn = 0;
      #1;
      chk("hrst_wpcir", 32'(wpcir_2), 1);
      chk("hrst_dbub", 32'(dbub_2), 0);
      tick();
      resetn = 1;
      pipe_clear();
      finst = I_ADD;
      tick();
      chk("hrst_post_wpcir", 32'(wpcir_2), 1);
      chk("hrst_post_dinst", dinst_2, I_ADD);

      // branch flush vs delay slot
      pipe_clear();
      taken = 1; finst = I_LW; fpc4 = 32'h200;
      tick();
      taken = 0;
      chk("br1_dinst", dinst_1, 0);
      chk("br1_dpc4", dpc4_1, 32'h200);
      chk("br2_dinst", dinst_2, I_LW);
      chk("br2_dpc4", dpc4_2, 32'h200);

      // stall and taken together: stall wins
      finst = I_ADD; fpc4 = 32'h2FC;
      tick();
      ex_load5(); use_rs = 1; taken = 1;
      finst = I_LW; fpc4 = 32'h300;
      tick();
      chk("stbr_dinst", dinst_1, I_ADD);
      chk("stbr_dpc4", dpc4_1, 32'h2FC);
      mem_load5();
      tick();
      chk("stbr_fl_dinst", dinst_1, 0);
      chk("stbr_fl_dpc4", dpc4_1, 32'h300);

      // load to $0: no stall, no forward
      pipe_clear();
      finst = I_Z; fpc4 = 32'h400;
      tick();
      ewreg = 1; em2reg = 1; ern = 0;
      mwreg = 1; mm2reg = 1; mrn = 0;
      wwreg = 1; wrn = 0;
      use_rs = 1; use_rt = 1;
      #2;
      chk("z_wpcir", 32'(wpcir_1), 1);
      chk("z_wpcir2", 32'(wpcir_2), 1);
      chk("z_fwda", 32'(fwda_1), 0);
      chk("z_fwdb", 32'(fwdb_1), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeid_hazard.md
# pipeid_hazard

Parametrised IF/ID pipeline register plus hazard and forwarding controller for the 5-stage pipeline. It holds the fetched instruction and PC+4 for decode and generates operand-forwarding selects from EX, MEM and WB. It stalls for load-use hazards with a configurable memory latency and optionally flushes the IF/ID register on a taken branch or jump. It sits between the IF stage and the decode datapath, which keeps the register file, control unit and operand muxes.

## Interface
Parameters:
- WIDTH, 32, datapath width of `fpc4`, `finst`, `dpc4`, `dinst`.
- RA_W, 5, register-number width.
- LOAD_LAT, 1, load-use stall cycles (1 or 2); 2 means load data is usable only from WB.
- BR_FLUSH, 0, 1 means a taken branch/jump squashes the IF/ID instruction; 0 means a delay slot.

Ports:
- clock  in  1  system clock, rising-edge active.
- resetn  in  1  reset: one clock; asynchronous, active-low.
- fpc4  in  WIDTH  PC+4 from IF.
- finst  in  WIDTH  fetched instruction from IF.
- dpc4  out  WIDTH  registered PC+4 for decode.
- dinst  out  WIDTH  registered instruction for decode.
- use_rs  in  1  decoded instruction reads rs (`dinst[25:21]`).
- use_rt  in  1  decoded instruction reads rt (`dinst[20:16]`).
- taken  in  1  control unit selects a non-sequential PC (pcsource != 0).
- ern, ewreg, em2reg  in  RA_W,1,1  EX-stage destination, write enable, load flag.
- mrn, mwreg, mm2reg  in  RA_W,1,1  MEM-stage destination, write enable, load flag.
- wrn, wwreg  in  RA_W,1  WB-stage destination, write enable.
- fwda, fwdb  out  3  operand selects: 0 regfile, 1 ealu, 2 malu, 3 mmo, 4 wdi.
- wpcir  out  1  1 means PC and IF/ID load this cycle.
- dbubble  out  1  1 means ID/EX captures a NOP (all write/mem enables cleared).

## Operation
- Forwarding, per operand with source s = rs for fwda and rt for fwdb:
  - s == 0 → 0.
  - else if ewreg & ern==s & !em2reg → 1.
  - else if mwreg & mrn==s → 3 if mm2reg, else 2.
  - else if wwreg & wrn==s → 4.
  - else → 0.
  - Priority is EX > MEM > WB. Selects are combinational and are valid even when the operand is unused.
- Load-use detect: `lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt))`.
- Stall counter `scnt` (2 bits), reset 0.
  - On lu & scnt==0: load LOAD_LAT-1.
  - On scnt!=0: decrement.
  - `stall = lu | (scnt!=0)`.
- Outputs: `wpcir = !stall`; `dbubble = stall`.
- States: RUN (scnt==0) and HOLD (scnt!=0). RUN→HOLD on lu when LOAD_LAT=2. HOLD→RUN after scnt reaches 0. HOLD never re-triggers, because EX then holds a bubble.
- IF/ID register, priority order:
  - stall → hold.
  - else if BR_FLUSH & taken → dinst←0 (NOP), dpc4←fpc4.
  - else → load fpc4 and finst.
- `taken` is ignored while stall=1: branch operands may be stale, and the branch re-evaluates after the stall.

## Timing
- Reset (asynchronous, active-low): dpc4=0, dinst=0, scnt=0. Resulting outputs: wpcir=1, dbubble=0, fwda=fwdb=0 (dinst=0 reads $0).
- IF/ID latency is 1 clock; all other outputs are combinational from current inputs and state.
- LOAD_LAT=1: one bubble per load-use hazard. The consumer gets fwd=3 (mmo) on the following cycle.
- LOAD_LAT=2: two bubbles. The consumer gets fwd=4 (wdi) on the second following cycle.
- Stall and flush in the same cycle: stall wins and the flush is dropped.
- Reset asserted mid-HOLD clears scnt immediately; the next cycle after release is RUN.
- A load to $0 never stalls and never forwards.

## Test plan
- Reset: assert resetn=0 mid-cycle → dpc4=0, dinst=0, wpcir=1, dbubble=0 at once, without a clock edge.
- EX forward: dinst rs=3; ewreg=1, ern=3, em2reg=0; mwreg=1, mrn=3 → fwda=1. Drop ewreg → fwda=2. Set mm2reg=1 → fwda=3. Then drop mwreg with wwreg=1, wrn=3 → fwda=4.
- Load-use, LOAD_LAT=1: `lw $5` in EX, ID `add $6,$5,$7` with use_rs=1 → one cycle with wpcir=0, dbubble=1 and dinst held. Next cycle fwda=3, wpcir=1.
- Load-use, LOAD_LAT=2: same stimulus → exactly two cycles with wpcir=0, then fwda=4. Assert resetn in the second stall cycle → scnt=0 and wpcir=1 after release.
- Branch flush, BR_FLUSH=1: taken=1, finst=0x8C220004 → next cycle dinst=0, dpc4=fpc4. Same with BR_FLUSH=0 → dinst=0x8C220004.
- Stall plus taken: lu=1 and taken=1 together → dinst is unchanged (not zeroed). The flush takes effect only in the first non-stalled cycle in which taken=1.
